// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks a block of 32-bit words in a synchronous-read data
// memory and streams each word, tagged with its byte address, over a
// valid/ready output interface. One beat is produced per READ/WAIT/SEND pass.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous active-low reset
//   start        : begin a dump (only honoured in IDLE)
//   base_addr    : byte address of the first word, captured on start
//   word_count   : number of words to read, captured on start
//   abort        : terminate the current dump (honoured in READ/WAIT/SEND)
//   mem_rd_en    : data-memory read strobe
//   mem_address  : data-memory byte address
//   mem_rd_data  : data-memory read data, one cycle after the address
//   dout_valid   : output beat valid
//   dout_ready   : downstream acceptance
//   dout_addr    : address of the current beat
//   dout_data    : memory word of the current beat
//   busy         : high in every state but IDLE
//   done         : one-cycle pulse when a dump ends (completion or abort)
module mem_dump_reader #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               abort,
  output logic               mem_rd_en,
  output logic [31:0]        mem_address,
  input  logic [31:0]        mem_rd_data,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [31:0]        dout_addr,
  output logic [31:0]        dout_data,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [COUNT_W-1:0] r_remaining;
  logic [31:0]        r_data;

  logic w_accept;
  logic w_xfer;

  assign w_accept = (r_state == IDLE) && start;
  assign w_xfer   = (r_state == SEND) && dout_ready;

  // Next-state logic. A beat that transfers in the same cycle as abort still
  // counts; either way SEND then leaves for DONE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (word_count == '0) ? DONE : READ;
        end
      end
      READ: w_next = abort ? DONE : WAIT;
      WAIT: w_next = abort ? DONE : SEND;
      SEND: begin
        if (w_xfer) begin
          w_next = (abort || (r_remaining == COUNT_W'(1))) ? DONE : READ;
        end else if (abort) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Address and remaining counter: loaded on start, stepped on every transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_addr      <= base_addr;
      r_remaining <= word_count;
    end else if (w_xfer) begin
      r_addr      <= r_addr + 32'd4;
      r_remaining <= r_remaining - COUNT_W'(1);
    end
  end

  // Memory data arrives during WAIT; it is held for the whole SEND phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (r_state == WAIT) begin
      r_data <= mem_rd_data;
    end
  end

  // All outputs decode registered state, so reset clears them immediately.
  assign mem_rd_en   = (r_state == READ);
  assign mem_address = r_addr;
  assign dout_valid  = (r_state == SEND);
  assign dout_addr   = r_addr;
  assign dout_data   = r_data;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   base_addr;
  logic [CW-1:0] word_count;
  logic          abort;
  logic          mem_rd_en;
  logic [31:0]   mem_address;
  logic [31:0]   mem_rd_data;
  logic          dout_valid;
  logic          dout_ready;
  logic [31:0]   dout_addr;
  logic [31:0]   dout_data;
  logic          busy;
  logic          done;

  mem_dump_reader #(.COUNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .abort       (abort),
    .mem_rd_en   (mem_rd_en),
    .mem_address (mem_address),
    .mem_rd_data (mem_rd_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_addr   (dout_addr),
    .dout_data   (dout_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data memory: explicit entries, otherwise a scrambled function of address.
  logic [31:0] mem_tab [logic [31:0]];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_tab.exists(a)) return mem_tab[a];
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_val(mem_address);
  end

  // Ready driver: 0 = low, 1 = high, 2 = random per cycle.
  int rdy_cfg = 1;
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_cfg)
        0:       dout_ready = 1'b0;
        1:       dout_ready = 1'b1;
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: cycle index advances at each negedge; events recorded there.
  int          cyc = 0;
  logic [63:0] obs_q[$];
  int          beat_cyc[$];
  int          rd_cnt, done_cnt, first_rd, first_valid, done_cyc;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (dout_valid && dout_ready) begin
        obs_q.push_back({dout_addr, dout_data});
        beat_cyc.push_back(cyc);
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (dout_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_obs();
    obs_q.delete();
    beat_cyc.delete();
    rd_cnt = 0; done_cnt = 0;
    first_rd = -1; first_valid = -1; done_cyc = -1;
  endtask

  int s_cyc;

  task automatic do_start(input logic [31:0] b, input int unsigned n);
    @(posedge clk);
    #1;
    base_addr  = b;
    word_count = n[CW-1:0];
    start      = 1'b1;
    s_cyc      = cyc + 1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = CW'($urandom);
  endtask

  task automatic wait_end();
    bit seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("idle_after_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Expected stream: n consecutive words from base, address wrapping mod 2^32.
  task automatic compare_dump(input logic [31:0] b, input int unsigned n, input bit fixed_rdy);
    logic [31:0] a;
    chk("beat_count", 64'(obs_q.size()), 64'(n));
    for (int unsigned i = 0; i < n && i < obs_q.size(); i++) begin
      a = b + 32'(i * 4);
      chk("beat", obs_q[i], {a, mem_val(a)});
    end
    for (int i = 1; i < beat_cyc.size(); i++)
      chk("beat_spacing_ge3", 64'(beat_cyc[i] - beat_cyc[i-1] >= 3), 64'd1);
    chk("rd_count", 64'(rd_cnt), 64'(n));
    chk("done_count", 64'(done_cnt), 64'd1);
    if (n == 0) begin
      chk("done_lat_cnt0", 64'(done_cyc - s_cyc), 64'd1);
      chk("valid_seen_cnt0", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      chk("rd_lat", 64'(first_rd - s_cyc), 64'd1);
      chk("valid_lat", 64'(first_valid - s_cyc), 64'd3);
      if (fixed_rdy) chk("done_lat", 64'(done_cyc - s_cyc), 64'(3 * n + 1));
    end
  endtask

  task automatic run_dump(input logic [31:0] b, input int unsigned n, input bit fixed_rdy);
    clear_obs();
    do_start(b, n);
    wait_end();
    compare_dump(b, n, fixed_rdy);
  endtask

  logic [31:0] rb;
  int unsigned rn;
  bit          seen_v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; word_count = '0;
    clear_obs();
    #1;
    chk("reset_outputs", {mem_rd_en, mem_address, dout_valid, busy, done},
        {1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    chk("reset_dout", {dout_addr, dout_data}, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    mem_tab[32'h60] = 32'h7;
    mem_tab[32'h64] = 32'h19;
    mem_tab[32'h14] = 32'h68;

    // Two-beat dump with ready held high.
    rdy_cfg = 1;
    run_dump(32'h60, 2, 1);

    // Zero-length dump.
    run_dump(32'h1234, 0, 1);

    // Back-pressure: ready low for 5 SEND cycles, data must hold.
    rdy_cfg = 0;
    clear_obs();
    do_start(32'h14, 1);
    seen_v = 0;
    for (int k = 0; k < 20 && !seen_v; k++) begin
      @(negedge clk);
      if (dout_valid) seen_v = 1;
    end
    chk("bp_valid_seen", 64'(seen_v), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {dout_valid, dout_addr, dout_data}, {1'b1, 32'h14, 32'h68});
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("bp_no_beat", 64'(obs_q.size()), 64'd0);
    rdy_cfg = 1;
    @(posedge clk);
    #1;
    chk("bp_first_ready_beat", 64'(obs_q.size()), 64'd1);
    wait_end();
    compare_dump(32'h14, 1, 0);

    // Address wrap.
    run_dump(32'hFFFF_FFFC, 2, 1);

    // Abort during the second READ; a start during the dump is ignored.
    rdy_cfg = 1;
    clear_obs();
    do_start(32'h100, 4);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1; start = 1'b1; base_addr = 32'h800; word_count = 8'd9;
    @(posedge clk);
    #1;
    abort = 1'b0; start = 1'b0;
    wait_end();
    chk("abort_beats", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) chk("abort_beat", obs_q[0], {32'h100, mem_val(32'h100)});
    chk("abort_rd_count", 64'(rd_cnt), 64'd2);
    chk("abort_done_count", 64'(done_cnt), 64'd1);
    chk("abort_done_lat", 64'(done_cyc - s_cyc), 64'd5);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_stays_idle", {busy, 32'(done_cnt), 32'(obs_q.size())}, {1'b0, 32'd1, 32'd1});

    // Reset in WAIT discards the dump.
    clear_obs();
    do_start(32'h200, 3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs", {mem_rd_en, mem_address, dout_valid, busy, done},
        {1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    chk("rst_mid_dout", {dout_addr, dout_data}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
    chk("rst_mid_idle", 64'(busy), 64'd0);
    run_dump(32'h60, 1, 1);

    // Randomized dumps with random back-pressure.
    for (int t = 0; t < 40; t++) begin
      rdy_cfg = ($urandom_range(0, 3) == 0) ? 1 : 2;
      rb = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      rn = $urandom_range(0, 6);
      run_dump(rb, rn, rdy_cfg == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
